// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory freeze with timeout detection, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             res,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic             IF_ID_uses_rs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RD,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           state, state_nxt;
  logic             pend_flush, pend_flush_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             timeout_nxt;
  logic             flush_evt;
  logic             load_use;

  assign load_use = ID_EX_MemRead && (ID_EX_RD != 5'd0) &&
                    ((ID_EX_RD == IF_ID_RS1) || (IF_ID_uses_rs2 && (ID_EX_RD == IF_ID_RS2)));

  // Next-state and pipeline controls; priority is busy > flush > load-use
  always_comb begin
    state_nxt      = state;
    pend_flush_nxt = pend_flush;
    wait_cnt_nxt   = wait_cnt;
    timeout_nxt    = mem_timeout;
    flush_evt      = 1'b0;
    PC_write       = 1'b1;
    IF_ID_write    = 1'b1;
    IF_ID_flush    = 1'b0;
    ID_EX_write    = 1'b1;
    ID_EX_flush    = 1'b0;
    EX_MEM_write   = 1'b1;

    if (res) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (dmem_busy) begin
      PC_write       = 1'b0;
      IF_ID_write    = 1'b0;
      ID_EX_write    = 1'b0;
      EX_MEM_write   = 1'b0;
      pend_flush_nxt = pend_flush | branch_taken;
      if (state == ST_RUN) begin
        state_nxt    = ST_WAIT;
        wait_cnt_nxt = CNT_W'(1);
      end else begin
        if (wait_cnt != CNT_MAX) wait_cnt_nxt = wait_cnt + CNT_W'(1);
        if (wait_cnt >= MAX_WAIT_C) timeout_nxt = 1'b1;
      end
    end else begin
      state_nxt    = ST_RUN;
      wait_cnt_nxt = '0;
      if (branch_taken || pend_flush) begin
        IF_ID_flush    = 1'b1;
        ID_EX_flush    = 1'b1;
        pend_flush_nxt = 1'b0;
        flush_evt      = 1'b1;
      end else if (load_use) begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
      end
    end
  end

  // State, sticky timeout and saturating perf counters
  always_ff @(posedge clk) begin
    if (res) begin
      state       <= ST_RUN;
      pend_flush  <= 1'b0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      pend_flush  <= pend_flush_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= timeout_nxt;
      if (!PC_write && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors queue their expected
// controls/counters, a negedge monitor pops and compares each cycle.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MAX_WAIT = 4;

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write}
  localparam logic [5:0] C_IDLE  = 6'b110101;
  localparam logic [5:0] C_FLUSH = 6'b111111;
  localparam logic [5:0] C_LU    = 6'b000111;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b001010;

  logic             clk = 1'b0;
  logic             res;
  logic [4:0]       rs1, rs2, rd;
  logic             uses_rs2, mem_read, br, busy;
  logic             pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, tmo;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    int         idx;
    logic [5:0] ctl;
    logic       to;
    int         stall;
    int         flush;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .res(res),
    .IF_ID_RS1(rs1), .IF_ID_RS2(rs2), .IF_ID_uses_rs2(uses_rs2),
    .ID_EX_MemRead(mem_read), .ID_EX_RD(rd),
    .branch_taken(br), .dmem_busy(busy),
    .PC_write(pc_w), .IF_ID_write(ifid_w), .IF_ID_flush(ifid_f),
    .ID_EX_write(idex_w), .ID_EX_flush(idex_f), .EX_MEM_write(exmem_w),
    .mem_timeout(tmo), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show in that cycle
  task automatic step(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u2, input logic mr, input logic [4:0] d,
                      input logic b, input logic bz, input logic [5:0] ctl,
                      input logic to, input int st, input int fl);
    exp_t e;
    @(posedge clk);
    #1;
    res = r; rs1 = s1; rs2 = s2; uses_rs2 = u2; mem_read = mr; rd = d;
    br = b; busy = bz;
    e.idx = n_step; e.ctl = ctl; e.to = to; e.stall = st; e.flush = fl;
    q.push_back(e);
    n_step++;
  endtask

  task automatic idle(input logic bz, input logic b, input logic [5:0] ctl,
                      input logic to, input int st, input int fl);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, b, bz, ctl, to, st, fl);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ctl", e.idx, int'({pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w}), int'(e.ctl));
      if (!$isunknown(e.to)) check("mem_timeout", e.idx, int'(tmo), int'(e.to));
      check("stall_cnt", e.idx, int'(stall_cnt), e.stall);
      check("flush_cnt", e.idx, int'(flush_cnt), e.flush);
    end
  end

  initial begin
    res = 1'b1; rs1 = '0; rs2 = '0; rd = '0;
    uses_rs2 = 1'b0; mem_read = 1'b0; br = 1'b0; busy = 1'b0;
    repeat (2) @(posedge clk);

    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_RST, 1'b0, 0, 0);
    idle(1'b0, 1'b0, C_IDLE, 1'b0, 0, 0);
    // load-use on rs1, then bubble has cleared MemRead
    step(1'b0, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_LU,   1'b0, 0, 0);
    idle(1'b0, 1'b0, C_IDLE, 1'b0, 1, 0);
    // x0 never hazards; rs2 ignored when not used
    step(1'b0, 5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_IDLE, 1'b0, 1, 0);
    step(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, C_IDLE, 1'b0, 1, 0);
    step(1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, C_LU,   1'b0, 1, 0);
    idle(1'b0, 1'b0, C_IDLE, 1'b0, 2, 0);
    // branch flush; then branch and load-use together
    idle(1'b0, 1'b1, C_FLUSH, 1'b0, 2, 0);
    idle(1'b0, 1'b0, C_IDLE,  1'b0, 2, 1);
    step(1'b0, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, C_FLUSH, 1'b0, 2, 1);
    idle(1'b0, 1'b0, C_IDLE, 1'b0, 2, 2);
    // busy 3 cycles with branch on the 2nd; flush lands when busy falls
    idle(1'b1, 1'b0, C_FRZ,   1'b0, 2, 2);
    idle(1'b1, 1'b1, C_FRZ,   1'b0, 3, 2);
    idle(1'b1, 1'b0, C_FRZ,   1'b0, 4, 2);
    idle(1'b0, 1'b0, C_FLUSH, 1'b0, 5, 2);
    idle(1'b0, 1'b0, C_IDLE,  1'b0, 5, 3);
    // busy 6 cycles with MAX_WAIT=4: timeout sticky once set
    idle(1'b1, 1'b0, C_FRZ, 1'b0, 5, 3);
    idle(1'b1, 1'b0, C_FRZ, 1'b0, 6, 3);
    idle(1'b1, 1'b0, C_FRZ, 1'b0, 7, 3);
    idle(1'b1, 1'b0, C_FRZ, 1'b0, 8, 3);
    idle(1'b1, 1'b0, C_FRZ, 1'bx, 9, 3);
    idle(1'b1, 1'b0, C_FRZ, 1'b1, 10, 3);
    idle(1'b0, 1'b0, C_IDLE, 1'b1, 11, 3);
    idle(1'b0, 1'b0, C_IDLE, 1'b1, 11, 3);
    // stall counter saturates at 15
    for (int k = 11; k <= 16; k++)
      step(1'b0, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, C_LU, 1'b1, (k > 15) ? 15 : k, 3);
    idle(1'b0, 1'b0, C_IDLE, 1'b1, 15, 3);
    // reset mid-WAIT with a pending flush
    idle(1'b1, 1'b1, C_FRZ, 1'b1, 15, 3);
    idle(1'b1, 1'b0, C_FRZ, 1'b1, 15, 3);
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_RST, 1'b1, 15, 3);
    idle(1'b0, 1'b0, C_IDLE, 1'b0, 0, 0);
    // flush counter saturates at 15
    for (int k = 0; k < 16; k++) idle(1'b0, 1'b1, C_FLUSH, 1'b0, 0, (k > 15) ? 15 : k);
    idle(1'b0, 1'b0, C_IDLE, 1'b0, 0, 15);

    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
